// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with valid/ready flow control, synchronous flush and
// Ctrl gating on bubbles. Define EX_MEM_SKID_EN for the two-entry skid buffer.
module ex_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] ReadData2_In,
    input  logic [DATA_W-1:0] ALUResult_In,
    input  logic [REG_W-1:0]  WR_In,
    input  logic [CTRL_W-1:0] Ctrl_In,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] ReadData2_Out,
    output logic [DATA_W-1:0] ALUResult_Out,
    output logic [REG_W-1:0]  WR_Out,
    output logic [CTRL_W-1:0] Ctrl_Out,
    output logic [1:0]        Occupancy
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_W-1:0]  wr;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rd2;
    } beat_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e state_q, state_d;
    beat_t  main_q, main_d;
    beat_t  in_beat;
    logic   accept, pop;

    assign in_beat   = '{ctrl: Ctrl_In, wr: WR_In, alu: ALUResult_In, rd2: ReadData2_In};
    assign Out_Valid = (state_q != EMPTY);
    assign pop       = Out_Valid & Out_Ready;
    assign accept    = In_Valid & In_Ready;

`ifdef EX_MEM_SKID_EN
    beat_t skid_q, skid_d;

    // Decoded from state only so upstream never sees a path from Out_Ready.
    assign In_Ready = (state_q != TWO);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = in_beat;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    main_d = in_beat;
                end else if (accept) begin
                    state_d = TWO;
                    skid_d  = in_beat;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (Flush) state_d = EMPTY;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) skid_q <= '0;
        else        skid_q <= skid_d;
    end
`else
    assign In_Ready = !Out_Valid | Out_Ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (accept) begin
            state_d = ONE;
            main_d  = in_beat;
        end else if (pop) begin
            state_d = EMPTY;
        end
        if (Flush) state_d = EMPTY;
    end
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    // Payload is left ungated; only control must not leak out of a bubble.
    assign ReadData2_Out = main_q.rd2;
    assign ALUResult_Out = main_q.alu;
    assign WR_Out        = main_q.wr;
    assign Ctrl_Out      = Out_Valid ? main_q.ctrl : '0;
    assign Occupancy     = state_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe; expectations follow the build (skid or single).
module tb_ex_mem_pipe;

    logic        Clk = 1'b0;
    logic        Rst_n, Flush, In_Valid, In_Ready, Out_Valid, Out_Ready;
    logic [31:0] ReadData2_In, ALUResult_In, ReadData2_Out, ALUResult_Out;
    logic [4:0]  WR_In, WR_Out;
    logic [3:0]  Ctrl_In, Ctrl_Out;
    logic [1:0]  Occupancy;

    int checks = 0;
    int failures = 0;

    ex_mem_pipe #(.DATA_W(32), .REG_W(5), .CTRL_W(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .ReadData2_In(ReadData2_In), .ALUResult_In(ALUResult_In),
        .WR_In(WR_In), .Ctrl_In(Ctrl_In),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .ReadData2_Out(ReadData2_Out), .ALUResult_Out(ALUResult_Out),
        .WR_Out(WR_Out), .Ctrl_Out(Ctrl_Out), .Occupancy(Occupancy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] wr,
                         input logic [3:0] ctrl);
        In_Valid     = v;
        ALUResult_In = alu;
        ReadData2_In = ~alu;
        WR_In        = wr;
        Ctrl_In      = ctrl;
        #1;
    endtask

    initial begin
        Rst_n = 1'b0; Flush = 1'b0; Out_Ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 4'd0);
        #2;
        chk("rst_out_valid", {31'b0, Out_Valid}, 32'd0);
        chk("rst_ctrl", {28'b0, Ctrl_Out}, 32'd0);
        chk("rst_alu", ALUResult_Out, 32'd0);
        chk("rst_rd2", ReadData2_Out, 32'd0);
        chk("rst_wr", {27'b0, WR_Out}, 32'd0);
        chk("rst_occ", {30'b0, Occupancy}, 32'd0);
        chk("rst_in_ready", {31'b0, In_Ready}, 32'd1);
        #8 Rst_n = 1'b1;
        tick();

        // Streaming: one beat per cycle, visible one cycle after acceptance.
        Out_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h10 + i, 5'(i), 4'b0100);
            chk("stream_in_ready", {31'b0, In_Ready}, 32'd1);
            tick();
            chk("stream_valid", {31'b0, Out_Valid}, 32'd1);
            chk("stream_alu", ALUResult_Out, 32'h10 + i);
            chk("stream_rd2", ReadData2_Out, ~(32'h10 + i));
            chk("stream_ctrl", {28'b0, Ctrl_Out}, 32'h4);
        end
        drive(1'b0, 32'h0, 5'd0, 4'd0);
        tick();
        chk("drain_valid", {31'b0, Out_Valid}, 32'd0);
        chk("drain_alu_hold", ALUResult_Out, 32'h17);

        // Bubble gating of control.
        Out_Ready = 1'b0;
        drive(1'b1, 32'h55, 5'd9, 4'b0001);
        tick();
        chk("bub_ctrl_live", {28'b0, Ctrl_Out}, 32'h1);
        Out_Ready = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 4'd0);
        tick();
        chk("bub_ctrl_gated", {28'b0, Ctrl_Out}, 32'h0);
        chk("bub_valid", {31'b0, Out_Valid}, 32'd0);
        chk("bub_alu_hold", ALUResult_Out, 32'h55);

        // Backpressure.
        Out_Ready = 1'b0;
        drive(1'b1, 32'h20, 5'd1, 4'b0100);
        chk("bp_ready0", {31'b0, In_Ready}, 32'd1);
        tick();
        chk("bp_occ1", {30'b0, Occupancy}, 32'd1);
        chk("bp_head20", ALUResult_Out, 32'h20);
`ifdef EX_MEM_SKID_EN
        drive(1'b1, 32'h21, 5'd2, 4'b0100);
        chk("bp_ready1", {31'b0, In_Ready}, 32'd1);
        tick();
        chk("bp_occ2", {30'b0, Occupancy}, 32'd2);
        chk("bp_ready_low", {31'b0, In_Ready}, 32'd0);
        drive(1'b1, 32'h22, 5'd3, 4'b0100);
        tick();
        chk("bp_hold_occ", {30'b0, Occupancy}, 32'd2);
        chk("bp_hold_head", ALUResult_Out, 32'h20);
        Out_Ready = 1'b1;
        #1;
        chk("bp_no_comb_ready", {31'b0, In_Ready}, 32'd0);
        tick();
        chk("bp_pop_head21", ALUResult_Out, 32'h21);
        chk("bp_pop_occ1", {30'b0, Occupancy}, 32'd1);
        chk("bp_ready_back", {31'b0, In_Ready}, 32'd1);
        tick();
        chk("bp_head22", ALUResult_Out, 32'h22);
        chk("bp_occ_22", {30'b0, Occupancy}, 32'd1);
`else
        drive(1'b1, 32'h21, 5'd2, 4'b0100);
        chk("bp_ready_comb_low", {31'b0, In_Ready}, 32'd0);
        tick();
        chk("bp_hold_occ", {30'b0, Occupancy}, 32'd1);
        chk("bp_hold_head", ALUResult_Out, 32'h20);
        Out_Ready = 1'b1;
        #1;
        chk("bp_ready_comb_high", {31'b0, In_Ready}, 32'd1);
        tick();
        chk("bp_head21", ALUResult_Out, 32'h21);
        chk("bp_occ_21", {30'b0, Occupancy}, 32'd1);
        drive(1'b1, 32'h22, 5'd3, 4'b0100);
        tick();
        chk("bp_head22", ALUResult_Out, 32'h22);
`endif
        drive(1'b0, 32'h0, 5'd0, 4'd0);
        tick();
        chk("bp_empty", {31'b0, Out_Valid}, 32'd0);

        // Flush kills held beats and the one entering alongside it.
        Out_Ready = 1'b0;
        drive(1'b1, 32'h30, 5'd3, 4'b0110);
        tick();
`ifdef EX_MEM_SKID_EN
        drive(1'b1, 32'h31, 5'd4, 4'b0110);
        tick();
        chk("fl_occ2", {30'b0, Occupancy}, 32'd2);
`else
        Out_Ready = 1'b1;
`endif
        chk("fl_head_wr3", {27'b0, WR_Out}, 32'd3);
        drive(1'b1, 32'h32, 5'd5, 4'b0110);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 4'd0);
        chk("fl_occ0", {30'b0, Occupancy}, 32'd0);
        chk("fl_valid", {31'b0, Out_Valid}, 32'd0);
        chk("fl_ctrl", {28'b0, Ctrl_Out}, 32'd0);
        Out_Ready = 1'b1;
        tick();
        chk("fl_no_wr5", {31'b0, Out_Valid}, 32'd0);

        // Asynchronous reset mid-operation.
        Out_Ready = 1'b0;
        drive(1'b1, 32'h99, 5'd7, 4'hF);
        tick();
        drive(1'b0, 32'h0, 5'd0, 4'd0);
        chk("ar_pre_valid", {31'b0, Out_Valid}, 32'd1);
        chk("ar_pre_ctrl", {28'b0, Ctrl_Out}, 32'hF);
        Rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, Out_Valid}, 32'd0);
        chk("ar_ctrl", {28'b0, Ctrl_Out}, 32'd0);
        chk("ar_alu", ALUResult_Out, 32'd0);
        chk("ar_wr", {27'b0, WR_Out}, 32'd0);
        chk("ar_occ", {30'b0, Occupancy}, 32'd0);
        chk("ar_in_ready", {31'b0, In_Ready}, 32'd1);
        #2 Rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
